// File: rtl/histo_readout_if.sv
// Byte-wide transmit handshake between the histogram serializer and the serial transmitter.
// Latency: none, wires only.
// Backpressure: the slave holds tx_ready low to stall; the master keeps tx_data stable while stalled.
interface histo_readout_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/histo_readout.sv
// Serializes per-channel phase-bin histograms as one framed byte stream (0xA5, then channel byte + bin words per channel).
// Latency: header presented the cycle after start; SETTLE_CYCLES idle cycles precede each channel; done the cycle after the last byte.
// Backpressure: tx_valid/tx_ready; tx_data held while stalled. Optional XOR checksum byte when HISTO_CSUM_EN is defined.
module histo_readout #(
    parameter int NCHAN          = 16,
    parameter int NBINS          = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter int SETTLE_CYCLES  = 2
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic [32*NBINS-1:0]   histos_in,
    output logic [7:0]            histotosend,
    histo_readout_if.master       tx,
    output logic                  busy,
    output logic                  done
);

    localparam int WW = (NBINS > 1) ? $clog2(NBINS) : 1;
    localparam int BW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [WW-1:0] WLAST  = WW'(NBINS - 1);
    localparam logic [BW-1:0] BLAST  = BW'(BYTES_PER_WORD - 1);
    localparam logic [7:0]    CHLAST = 8'(NCHAN - 1);
    localparam logic [7:0]    HDR_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_SETTLE,
        S_SEND,
`ifdef HISTO_CSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    state_t               state;
    logic [3:0]           cnt;
    logic [32*NBINS-1:0]  snap;
    logic [WW-1:0]        wsel;
    logic [BW-1:0]        bsel;
    logic                 chan_phase;   // the channel byte is the one currently presented
    logic [WW-1:0]        nw;
    logic [BW-1:0]        nb;
    logic                 last_byte;
    logic                 xfer;
`ifdef HISTO_CSUM_EN
    logic [7:0]           csum;
`endif

    // Select byte b (MSB-first among the low BYTES_PER_WORD bytes) of bin word w.
    function automatic logic [7:0] pick(input logic [32*NBINS-1:0] s,
                                        input logic [WW-1:0] w,
                                        input logic [BW-1:0] b);
        logic [31:0] wd;
        wd = s[32*int'(w) +: 32];
        return 8'(wd >> (8 * (BYTES_PER_WORD - 1 - int'(b))));
    endfunction

    assign xfer = tx.tx_valid && tx.tx_ready;

    // Position of the byte following the current one, and end-of-channel detect.
    always_comb begin
        nb        = bsel + 1'b1;
        nw        = wsel;
        if (bsel == BLAST) begin
            nb = '0;
            nw = wsel + 1'b1;
        end
        last_byte = (wsel == WLAST) && (bsel == BLAST) && !chan_phase;
    end

    // Frame sequencer: owns every output and the snapshot register.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state       <= S_IDLE;
            histotosend <= '0;
            tx.tx_valid <= 1'b0;
            tx.tx_data  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cnt         <= '0;
            wsel        <= '0;
            bsel        <= '0;
            chan_phase  <= 1'b0;
`ifdef HISTO_CSUM_EN
            csum        <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state       <= S_HDR;
                        histotosend <= '0;
                        busy        <= 1'b1;
                        tx.tx_valid <= 1'b1;
                        tx.tx_data  <= HDR_BYTE;
`ifdef HISTO_CSUM_EN
                        csum        <= '0;
`endif
                    end
                end
                S_HDR: begin
                    if (xfer) begin
                        state       <= S_SETTLE;
                        cnt         <= 4'(SETTLE_CYCLES);
                        tx.tx_valid <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (cnt <= 4'd1) begin
                        snap        <= histos_in;
                        tx.tx_data  <= histotosend;
                        tx.tx_valid <= 1'b1;
                        chan_phase  <= 1'b1;
                        wsel        <= '0;
                        bsel        <= '0;
                        state       <= S_SEND;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_SEND: begin
                    if (xfer) begin
`ifdef HISTO_CSUM_EN
                        csum <= csum ^ tx.tx_data;
`endif
                        if (chan_phase) begin
                            chan_phase <= 1'b0;
                            tx.tx_data <= pick(snap, wsel, bsel);
                        end else if (last_byte) begin
                            if (histotosend != CHLAST) begin
                                histotosend <= histotosend + 1'b1;
                                cnt         <= 4'(SETTLE_CYCLES);
                                tx.tx_valid <= 1'b0;
                                state       <= S_SETTLE;
                            end else begin
`ifdef HISTO_CSUM_EN
                                tx.tx_data  <= csum ^ tx.tx_data;
                                state       <= S_CSUM;
`else
                                tx.tx_valid <= 1'b0;
                                busy        <= 1'b0;
                                done        <= 1'b1;
                                state       <= S_DONE;
`endif
                            end
                        end else begin
                            wsel       <= nw;
                            bsel       <= nb;
                            tx.tx_data <= pick(snap, nw, nb);
                        end
                    end
                end
`ifdef HISTO_CSUM_EN
                S_CSUM: begin
                    if (xfer) begin
                        tx.tx_valid <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_histo_readout.sv
module tb_histo_readout;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         nrst;
    logic         start;
    logic         tx_ready;
    logic         sel_g;
    logic         corrupt;
    logic         start_a, start_b;
    logic [255:0] histos_a, histos_b;
    logic [7:0]   hts_a, hts_b;
    logic         busy_a, busy_b, done_a, done_b;

    logic [31:0]  bins_a [2][8];
    logic [31:0]  bins_b [8];

    histo_readout_if if_a ();
    histo_readout_if if_b ();

    assign start_a       = start & ~sel_g;
    assign start_b       = start & sel_g;
    assign if_a.tx_ready = tx_ready;
    assign if_b.tx_ready = tx_ready;

    histo_readout #(.NCHAN(2), .NBINS(8), .BYTES_PER_WORD(4), .SETTLE_CYCLES(2)) dut_a (
        .clk(clk), .nrst(nrst), .start(start_a), .histos_in(histos_a),
        .histotosend(hts_a), .tx(if_a), .busy(busy_a), .done(done_a));

    histo_readout #(.NCHAN(1), .NBINS(8), .BYTES_PER_WORD(1), .SETTLE_CYCLES(3)) dut_b (
        .clk(clk), .nrst(nrst), .start(start_b), .histos_in(histos_b),
        .histotosend(hts_b), .tx(if_b), .busy(busy_b), .done(done_b));

    // Histogram stage stand-in: bins of the selected channel, optionally inverted to disturb the snapshot.
    always_comb begin
        histos_a = '0;
        histos_b = '0;
        for (int k = 0; k < 8; k++) begin
            histos_a[32*k +: 32] = bins_a[hts_a[0]][k] ^ {32{corrupt}};
            histos_b[32*k +: 32] = bins_b[k] ^ {32{corrupt}};
        end
    end

    logic       cur_valid, cur_busy, cur_done;
    logic [7:0] cur_data, cur_hts;
    always_comb begin
        cur_valid = sel_g ? if_b.tx_valid : if_a.tx_valid;
        cur_data  = sel_g ? if_b.tx_data  : if_a.tx_data;
        cur_busy  = sel_g ? busy_b        : busy_a;
        cur_done  = sel_g ? done_b        : done_a;
        cur_hts   = sel_g ? hts_b         : hts_a;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit         s;
        int         idx;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs [$];
    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];
    logic [7:0] hts_log [$];

    // Reference frame built from the stand-in bin tables.
    task automatic build_exp(input bit s);
        int nch, bpw;
        logic [7:0]  x;
        logic [31:0] w;
        nch = s ? 1 : 2;
        bpw = s ? 1 : 4;
        x   = 8'h00;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int c = 0; c < nch; c++) begin
            exp_q.push_back(8'(c));
            x ^= 8'(c);
            for (int k = 0; k < 8; k++) begin
                w = s ? bins_b[k] : bins_a[c][k];
                for (int b = 0; b < bpw; b++) begin
                    exp_q.push_back(8'(w >> (8 * (bpw - 1 - b))));
                    x ^= 8'(w >> (8 * (bpw - 1 - b)));
                end
            end
        end
`ifdef HISTO_CSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic run_frame(input bit s, input bit rnd, input bit cmode, input bit dup);
        int         last_x, done_cyc, ndone, second_cyc, settle;
        bit         prev_stall;
        logic [7:0] prev_d;
        sel_g      = s;
        settle     = s ? 3 : 2;
        got_q.delete();
        hts_log.delete();
        last_x     = -1;
        done_cyc   = -1;
        second_cyc = -1;
        ndone      = 0;
        prev_stall = 1'b0;
        prev_d     = 8'h00;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (cmode) corrupt = cur_valid;
            tx_ready = rnd ? ($urandom_range(0, 99) >= 30) : 1'b1;
            if (dup && (cyc == 5 || cur_done)) start = 1'b1;
            else start = 1'b0;
            if (prev_stall) chk("hold_data", cur_data, prev_d);
            if (cyc == 0) begin
                chk("hdr_valid", cur_valid, 1);
                chk("hdr_data", cur_data, 8'hA5);
                chk("hdr_busy", cur_busy, 1);
                chk("hdr_sel", cur_hts, 0);
            end
            if (cur_busy && (hts_log.size() == 0 || hts_log[$] != cur_hts)) hts_log.push_back(cur_hts);
            if (cur_done) begin
                ndone++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    chk("busy_at_done", cur_busy, 0);
                end
            end
            if (cur_valid && tx_ready) begin
                got_q.push_back(cur_data);
                if (got_q.size() == 2) second_cyc = cyc;
                last_x = cyc;
            end
            prev_stall = cur_valid && !tx_ready;
            prev_d     = cur_data;
            if (done_cyc >= 0 && cyc > done_cyc + 20) break;
        end
        start    = 1'b0;
        tx_ready = 1'b1;
        corrupt  = 1'b0;
        chk("done_seen", (done_cyc >= 0), 1);
        chk("done_once", ndone, 1);
        chk("done_after_last", done_cyc, last_x + 1);
        chk("busy_end", cur_busy, 0);
        if (!rnd) chk("first_chan_cycle", second_cyc, 1 + settle);
        if (s) chk("sel_steps", hts_log.size(), 1);
        else begin
            chk("sel_steps", hts_log.size(), 2);
            if (hts_log.size() == 2) begin
                chk("sel_step0", hts_log[0], 0);
                chk("sel_step1", hts_log[1], 1);
            end
        end
        build_exp(s);
        chk("frame_len", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("byte%0d", i), got_q[i], exp_q[i]);
    endtask

    task automatic apply_vecs(input bit s);
        foreach (vecs[i]) begin
            if (vecs[i].s == s) begin
                if (vecs[i].idx < got_q.size())
                    chk($sformatf("vec_%0d_idx%0d", s, vecs[i].idx), got_q[vecs[i].idx], vecs[i].exp);
                else
                    chk($sformatf("vec_%0d_idx%0d_missing", s, vecs[i].idx), got_q.size(), vecs[i].idx + 1);
            end
        end
    endtask

    initial begin
        int len_a, len_b;
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < 8; k++) bins_a[c][k] = 32'h0;
        for (int k = 0; k < 8; k++) bins_b[k] = 32'h0;
        bins_a[0][0] = 32'h0000_0012;
        bins_a[1][3] = 32'hDEAD_BEEF;
        bins_a[1][7] = 32'h0102_0304;
        bins_b[0]    = 32'h0000_01FF;
        bins_b[1]    = 32'h1234_5678;

        vecs.push_back('{0, 0, 8'hA5});
        vecs.push_back('{0, 1, 8'h00});
        vecs.push_back('{0, 2, 8'h00});
        vecs.push_back('{0, 3, 8'h00});
        vecs.push_back('{0, 4, 8'h00});
        vecs.push_back('{0, 5, 8'h12});
        vecs.push_back('{0, 34, 8'h01});
        vecs.push_back('{0, 47, 8'hDE});
        vecs.push_back('{0, 48, 8'hAD});
        vecs.push_back('{0, 49, 8'hBE});
        vecs.push_back('{0, 50, 8'hEF});
        vecs.push_back('{0, 63, 8'h01});
        vecs.push_back('{0, 66, 8'h04});
        vecs.push_back('{1, 0, 8'hA5});
        vecs.push_back('{1, 1, 8'h00});
        vecs.push_back('{1, 2, 8'hFF});
        vecs.push_back('{1, 3, 8'h78});
        vecs.push_back('{1, 9, 8'h00});
`ifdef HISTO_CSUM_EN
        vecs.push_back('{1, 10, 8'h87});
        len_a = 68;
        len_b = 11;
`else
        len_a = 67;
        len_b = 10;
`endif

        nrst     = 1'b0;
        start    = 1'b0;
        tx_ready = 1'b0;
        sel_g    = 1'b0;
        corrupt  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_valid", if_a.tx_valid, 0);
        chk("rst_data", if_a.tx_data, 0);
        chk("rst_sel", hts_a, 0);
        nrst = 1'b1;
        @(negedge clk);

        // Plain frame, 4-byte words.
        run_frame(1'b0, 1'b0, 1'b0, 1'b0);
        chk("len_a", got_q.size(), len_a);
        apply_vecs(1'b0);

        // Random stalls, disturbed inputs after each snapshot, extra starts while busy and at done.
        run_frame(1'b0, 1'b1, 1'b1, 1'b1);

        // Truncated 1-byte words, longer settle.
        run_frame(1'b1, 1'b0, 1'b0, 1'b0);
        chk("len_b", got_q.size(), len_b);
        apply_vecs(1'b1);

        // Reset in the middle of channel 0 data.
        sel_g = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        tx_ready = 1'b1;
        repeat (12) @(negedge clk);
        chk("mid_busy", busy_a, 1);
        chk("mid_valid", if_a.tx_valid, 1);
        nrst = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst_busy", busy_a, 0);
        chk("mrst_done", done_a, 0);
        chk("mrst_valid", if_a.tx_valid, 0);
        chk("mrst_data", if_a.tx_data, 0);
        chk("mrst_sel", hts_a, 0);
        @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", busy_a, 0);

        // Clean frame after the abandoned one.
        run_frame(1'b0, 1'b0, 1'b0, 1'b0);
        apply_vecs(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
